// File: rtl/in_feature_loader_pkg.sv
// ---------------------------------------------------------------------------
// in_feature_loader_pkg
//   Shared constants and types for the layer-1 input feature loader.
//   - DATA_WIDTH                     : pixel / RAM word width
//   - LAYER1_IN_FEATURE_ADDR_WIDTH   : in_feature RAM address width
//   - LAYER1_IN_FEATURE_WORDS        : words per frame (32x32 image)
//   - loader_state_t                 : loader FSM state encoding
// ---------------------------------------------------------------------------
package in_feature_loader_pkg;

    localparam int DATA_WIDTH                   = 16;
    localparam int LAYER1_IN_FEATURE_ADDR_WIDTH = 11;
    localparam int LAYER1_IN_FEATURE_WORDS      = 1024;

    typedef enum logic [2:0] {
        LD_IDLE  = 3'd0,  // waiting for enable, stream stalled
        LD_LOAD  = 3'd1,  // storing words into in_feature
        LD_DRAIN = 3'd2,  // over-long frame: swallow words until s_last
        LD_START = 3'd3,  // one-cycle network reset
        LD_RUN   = 3'd4   // network enabled until net_done
    } loader_state_t;

endpackage

// File: rtl/in_feature_loader.sv
// ---------------------------------------------------------------------------
// in_feature_loader
//   Fills the layer-1 in_feature RAM (write side of port A) from a
//   valid/ready pixel stream, one frame at a time, then sequences the CNN:
//   a one-cycle net_reset pulse followed by net_enable held until net_done.
//
// Ports
//   clock, reset        : rising-edge clock, synchronous active-high reset
//   enable              : block enable; low parks the block in IDLE between
//                         frames (never aborts a frame or a run in progress)
//   s_valid/s_data/     : input pixel stream, s_last marks the final word
//   s_last/s_ready
//   mem_address_a/      : registered RAM write port (1-cycle write latency)
//   mem_data_a/
//   mem_wren_a
//   net_reset           : one-cycle pulse before each network run
//   net_enable          : level held for the whole network run
//   net_done            : network finished; only honoured while running
//   frame_done          : one-cycle pulse per completed run
//   err_short           : pulse when s_last arrives before a full frame
//   err_long            : pulse when a full frame has no s_last on its end
// ---------------------------------------------------------------------------
module in_feature_loader
    import in_feature_loader_pkg::*;
#(
    parameter int DATA_WIDTH = in_feature_loader_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = LAYER1_IN_FEATURE_ADDR_WIDTH,
    // Must not exceed 2**ADDR_WIDTH.
    parameter int NUM_WORDS  = LAYER1_IN_FEATURE_WORDS
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  s_valid,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_last,
    output logic                  s_ready,
    output logic [ADDR_WIDTH-1:0] mem_address_a,
    output logic [DATA_WIDTH-1:0] mem_data_a,
    output logic                  mem_wren_a,
    output logic                  net_reset,
    output logic                  net_enable,
    input  logic                  net_done,
    output logic                  frame_done,
    output logic                  err_short,
    output logic                  err_long
);

    // One spare bit so the counter can sit at NUM_WORDS after a long frame
    // without wrapping back onto a valid address.
    typedef logic [ADDR_WIDTH:0] wcnt_t;

    localparam wcnt_t LAST_IDX = wcnt_t'(NUM_WORDS - 1);

    loader_state_t state;
    wcnt_t         wcnt;

    // Decoded from the state register only, so ready never depends on valid.
    assign s_ready = (state == LD_LOAD) || (state == LD_DRAIN);

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= LD_IDLE;
            wcnt          <= '0;
            mem_address_a <= '0;
            mem_data_a    <= '0;
            mem_wren_a    <= 1'b0;
            net_reset     <= 1'b0;
            net_enable    <= 1'b0;
            frame_done    <= 1'b0;
            err_short     <= 1'b0;
            err_long      <= 1'b0;
        end else begin
            // Pulse outputs default low; net_enable and the write address /
            // data hold their value.
            mem_wren_a <= 1'b0;
            net_reset  <= 1'b0;
            frame_done <= 1'b0;
            err_short  <= 1'b0;
            err_long   <= 1'b0;

            unique case (state)
                LD_IDLE: begin
                    if (enable) state <= LD_LOAD;
                end

                LD_LOAD: begin
                    if (s_valid) begin
                        // Every accepted word is written, including the one
                        // that carries an early s_last.
                        mem_wren_a    <= 1'b1;
                        mem_address_a <= wcnt[ADDR_WIDTH-1:0];
                        mem_data_a    <= s_data;
                        if (wcnt == LAST_IDX) begin
                            wcnt <= wcnt + 1'b1;
                            if (s_last) begin
                                state     <= LD_START;
                                net_reset <= 1'b1;
                            end else begin
                                err_long <= 1'b1;
                                state    <= LD_DRAIN;
                            end
                        end else if (s_last) begin
                            // Partial frame is abandoned; next word lands at 0.
                            err_short <= 1'b1;
                            wcnt      <= '0;
                        end else begin
                            wcnt <= wcnt + 1'b1;
                        end
                    end
                end

                LD_DRAIN: begin
                    // Surplus words are accepted but never written.
                    if (s_valid && s_last) begin
                        state     <= LD_START;
                        net_reset <= 1'b1;
                    end
                end

                LD_START: begin
                    state      <= LD_RUN;
                    net_enable <= 1'b1;
                end

                LD_RUN: begin
                    if (net_done) begin
                        net_enable <= 1'b0;
                        frame_done <= 1'b1;
                        wcnt       <= '0;
                        state      <= enable ? LD_LOAD : LD_IDLE;
                    end
                end

                default: begin
                    state      <= LD_IDLE;
                    net_enable <= 1'b0;
                    wcnt       <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_in_feature_loader.sv
// ---------------------------------------------------------------------------
// tb_in_feature_loader
//   Table of whole-frame scenarios (word count, s_last position, idle-gap
//   rate, expected write count / error pulses / network run), followed by
//   hand-written sequences for enable drop, stray net_done and mid-frame
//   reset. A negedge monitor tracks the expected write address stream.
// ---------------------------------------------------------------------------
module tb_in_feature_loader;

    localparam int DW = 16;
    localparam int AW = 11;
    localparam int NW = 1024;

    logic          clock = 1'b0;
    logic          reset;
    logic          enable;
    logic          s_valid;
    logic [DW-1:0] s_data;
    logic          s_last;
    logic          s_ready;
    logic [AW-1:0] mem_address_a;
    logic [DW-1:0] mem_data_a;
    logic          mem_wren_a;
    logic          net_reset;
    logic          net_enable;
    logic          net_done;
    logic          frame_done;
    logic          err_short;
    logic          err_long;

    in_feature_loader dut (
        .clock         (clock),
        .reset         (reset),
        .enable        (enable),
        .s_valid       (s_valid),
        .s_data        (s_data),
        .s_last        (s_last),
        .s_ready       (s_ready),
        .mem_address_a (mem_address_a),
        .mem_data_a    (mem_data_a),
        .mem_wren_a    (mem_wren_a),
        .net_reset     (net_reset),
        .net_enable    (net_enable),
        .net_done      (net_done),
        .frame_done    (frame_done),
        .err_short     (err_short),
        .err_long      (err_long)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    // ---------------- monitor: expected write stream ----------------
    int wr_total     = 0;
    int wr_bad       = 0;
    int short_total  = 0;
    int long_total   = 0;
    int nreset_total = 0;
    int done_total   = 0;
    int exp_addr     = 0;

    always @(negedge clock) begin
        if (mem_wren_a) begin
            wr_total++;
            // Pixel k is sent with value k, so data must equal its address.
            if (int'(mem_address_a) != exp_addr || int'(mem_data_a) != int'(mem_address_a))
                wr_bad++;
            exp_addr++;
        end
        if (err_short) short_total++;
        if (err_long) begin
            long_total++;
            // err_long lines up with the write of the last frame word.
            if (!(mem_wren_a && int'(mem_address_a) == NW - 1)) wr_bad++;
        end
        if (net_reset)  nreset_total++;
        if (frame_done) done_total++;
        if (reset || err_short || frame_done) exp_addr = 0;
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_hs();
        int n = 0;
        while (!s_ready && n < 100) begin
            step();
            n++;
        end
        if (!s_ready) begin
            chk("handshake_timeout", int'(s_ready), 1);
            $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
            $fatal(1, "handshake timeout");
        end
        step();
    endtask

    task automatic send_frame(input int nwords, input int last_at, input int gap_pct);
        for (int k = 0; k < nwords; k++) begin
            int g = 0;
            while (g < 4 && int'($urandom_range(99)) < gap_pct) begin
                step();
                g++;
            end
            s_valid = 1'b1;
            s_data  = DW'(k);
            s_last  = (k == last_at);
            wait_hs();
            s_valid = 1'b0;
            s_last  = 1'b0;
        end
    endtask

    // Called in the cycle after the final handshake: START, then RUN for
    // 50 cycles, then net_done and its frame_done response.
    task automatic complete_run(input string tag, input int wr_at_start);
        chk({tag, "_net_reset"}, int'(net_reset), 1);
        chk({tag, "_wren_at_start"}, int'(mem_wren_a), wr_at_start);
        if (wr_at_start == 1) chk({tag, "_last_addr"}, int'(mem_address_a), NW - 1);
        step();
        chk({tag, "_net_enable_rise"}, int'(net_enable), 1);
        chk({tag, "_net_reset_fall"}, int'(net_reset), 0);
        chk({tag, "_ready_in_run"}, int'(s_ready), 0);
        repeat (50) step();
        chk({tag, "_net_enable_held"}, int'(net_enable), 1);
        net_done = 1'b1;
        step();
        net_done = 1'b0;
        chk({tag, "_frame_done"}, int'(frame_done), 1);
        chk({tag, "_net_enable_fall"}, int'(net_enable), 0);
        chk({tag, "_ready_after"}, int'(s_ready), int'(enable));
        step();
        chk({tag, "_frame_done_pulse"}, int'(frame_done), 0);
    endtask

    typedef struct {
        string name;
        int    nwords;
        int    last_at;
        int    gap_pct;
        int    exp_writes;
        int    exp_short;
        int    exp_long;
        int    completes;
        int    wr_at_start;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int w0, b0, s0, l0, r0, d0;

        vecs[0] = '{"nominal", 1024, 1023,  0, 1024, 0, 0, 1, 1};
        vecs[1] = '{"gaps",    1024, 1023, 30, 1024, 0, 0, 1, 1};
        vecs[2] = '{"short",     10,    9,  0,   10, 1, 0, 0, 0};
        vecs[3] = '{"after_sh",1024, 1023,  0, 1024, 0, 0, 1, 1};
        vecs[4] = '{"long",    1030, 1029,  0, 1024, 0, 1, 1, 0};

        reset    = 1'b1;
        enable   = 1'b0;
        s_valid  = 1'b0;
        s_data   = '0;
        s_last   = 1'b0;
        net_done = 1'b0;
        repeat (3) step();

        chk("rst_s_ready",    int'(s_ready), 0);
        chk("rst_wren",       int'(mem_wren_a), 0);
        chk("rst_addr",       int'(mem_address_a), 0);
        chk("rst_data",       int'(mem_data_a), 0);
        chk("rst_net_reset",  int'(net_reset), 0);
        chk("rst_net_enable", int'(net_enable), 0);
        chk("rst_frame_done", int'(frame_done), 0);
        chk("rst_errs",       int'({err_short, err_long}), 0);

        reset = 1'b0;
        step();
        chk("idle_ready", int'(s_ready), 0);
        enable = 1'b1;
        step();
        chk("load_ready", int'(s_ready), 1);

        // Stray net_done while loading must be ignored.
        net_done = 1'b1;
        step();
        net_done = 1'b0;
        chk("stray_done_frame_done", int'(frame_done), 0);
        chk("stray_done_ready", int'(s_ready), 1);

        for (int v = 0; v < 5; v++) begin
            w0 = wr_total; b0 = wr_bad; s0 = short_total;
            l0 = long_total; r0 = nreset_total; d0 = done_total;
            send_frame(vecs[v].nwords, vecs[v].last_at, vecs[v].gap_pct);
            if (vecs[v].completes != 0) begin
                complete_run(vecs[v].name, vecs[v].wr_at_start);
            end else begin
                chk({vecs[v].name, "_err_short_now"}, int'(err_short), vecs[v].exp_short);
                chk({vecs[v].name, "_no_net_reset"}, int'(net_reset), 0);
                step();
            end
            step();
            chk({vecs[v].name, "_writes"},    wr_total - w0,     vecs[v].exp_writes);
            chk({vecs[v].name, "_wr_stream"}, wr_bad - b0,       0);
            chk({vecs[v].name, "_err_short"}, short_total - s0,  vecs[v].exp_short);
            chk({vecs[v].name, "_err_long"},  long_total - l0,   vecs[v].exp_long);
            chk({vecs[v].name, "_resets"},    nreset_total - r0, vecs[v].completes);
            chk({vecs[v].name, "_dones"},     done_total - d0,   vecs[v].completes);
        end

        // Enable dropped mid-run: run completes, then IDLE until re-enabled.
        send_frame(NW, NW - 1, 0);
        chk("endrop_net_reset", int'(net_reset), 1);
        step();
        chk("endrop_net_enable", int'(net_enable), 1);
        enable = 1'b0;
        repeat (10) step();
        chk("endrop_enable_held", int'(net_enable), 1);
        net_done = 1'b1;
        step();
        net_done = 1'b0;
        chk("endrop_frame_done", int'(frame_done), 1);
        chk("endrop_net_enable_fall", int'(net_enable), 0);
        chk("endrop_ready_low", int'(s_ready), 0);
        repeat (3) step();
        chk("endrop_idle_ready", int'(s_ready), 0);
        enable = 1'b1;
        step();
        chk("endrop_resume_ready", int'(s_ready), 1);

        // Reset after word 500, then a full frame from address 0.
        w0 = wr_total; b0 = wr_bad;
        send_frame(501, -1, 0);
        reset = 1'b1;
        step();
        chk("midrst_ready", int'(s_ready), 0);
        chk("midrst_wren",  int'(mem_wren_a), 0);
        chk("midrst_addr",  int'(mem_address_a), 0);
        chk("midrst_data",  int'(mem_data_a), 0);
        chk("midrst_net",   int'({net_reset, net_enable, frame_done, err_short, err_long}), 0);
        reset = 1'b0;
        step();
        send_frame(NW, NW - 1, 0);
        complete_run("midrst", 1);
        step();
        chk("midrst_writes",    wr_total - w0, 501 + NW);
        chk("midrst_wr_stream", wr_bad - b0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/in_feature_loader.md
# in_feature_loader

Front-end stage that fills the layer-1 input feature RAM (`in_feature`, write side of port A) from a valid/ready pixel stream, one frame at a time. Once a full frame is stored it sequences the CNN pipeline: a one-cycle reset pulse, then a held enable until the network reports done. It sits directly upstream of `cnp`, driving the RAM write port and the network `enable`/`reset` inputs that `cnp` otherwise takes from the top level.

## Interface
- `DATA_WIDTH`, 16, pixel and RAM word width.
- `ADDR_WIDTH`, 11, in_feature RAM address width.
- `NUM_WORDS`, 1024, words per frame (32x32 image); must be ≤ 2^ADDR_WIDTH.

Ports:
- `clock`, in, 1: single clock; all logic rising-edge.
- `reset`, in, 1: synchronous, active-high.
- `enable`, in, 1: block enable; when low, the block stays in or returns to IDLE between frames.
- `s_valid`, in, 1: stream word valid.
- `s_data`, in, DATA_WIDTH: stream pixel.
- `s_last`, in, 1: marks the final word of a frame.
- `s_ready`, out, 1: block accepts a word this cycle.
- `mem_address_a`, out, ADDR_WIDTH: RAM write address.
- `mem_data_a`, out, DATA_WIDTH: RAM write data.
- `mem_wren_a`, out, 1: RAM write enable.
- `net_reset`, out, 1: reset pulse to `cnp`.
- `net_enable`, out, 1: enable level to `cnp`.
- `net_done`, in, 1: network finished (final-layer done).
- `frame_done`, out, 1: one-cycle pulse per completed network run.
- `err_short`, out, 1: one-cycle pulse when `s_last` arrives before NUM_WORDS words.
- `err_long`, out, 1: one-cycle pulse when word NUM_WORDS-1 is accepted without `s_last`.

## Operation
- States: IDLE, LOAD, DRAIN, START, RUN.
- **IDLE:** `s_ready`=0. Moves to LOAD when `enable`=1.
- **LOAD:** `s_ready`=1. Each handshake (`s_valid & s_ready`) writes `s_data` at address `wcnt`, then increments `wcnt`.
  - `s_last` on word index < NUM_WORDS-1: pulse `err_short`, clear `wcnt`, stay in LOAD. The partial frame is discarded and the next word is written to address 0.
  - Word NUM_WORDS-1 with `s_last`: go to START.
  - Word NUM_WORDS-1 without `s_last`: pulse `err_long`, go to DRAIN.
- **DRAIN:** `s_ready`=1. Accepted words are dropped with no write. Moves to START on the handshake carrying `s_last`.
- **START:** `net_reset`=1 for exactly one cycle. Moves to RUN.
- **RUN:** `net_enable`=1 and `s_ready`=0.
  - On `net_done`=1: `net_enable` falls, `frame_done` pulses, `wcnt` clears.
  - Next state is LOAD if `enable`=1, otherwise IDLE.
- `enable` falling during LOAD, DRAIN or RUN does not abort. The current frame or run completes, then the block goes to IDLE.
- `wcnt` is ADDR_WIDTH+1 bits wide and never wraps: it is cleared on frame completion, on short error and on reset.
- Reset at any point, including mid-frame or mid-run: state to IDLE, `wcnt` to 0, all outputs 0 on the next edge. The partially written RAM contents are not cleared.

## Timing
- Reset value of every output is 0.
- `s_ready` is decoded from the state register only. It does not depend combinationally on `s_valid`.
- Write latency is 1 cycle. A handshake at edge N produces registered `mem_wren_a`/`mem_address_a`/`mem_data_a` during cycle N+1.
- `mem_wren_a` is high for exactly one cycle per stored word. Back-to-back handshakes give back-to-back writes.
- Last handshake at edge N → START during cycle N+1 (`net_reset`=1, and the final RAM write occurs in the same cycle) → RUN from N+2 (`net_enable`=1).
- `net_done` sampled at edge M → `net_enable`=0 and `frame_done`=1 in cycle M+1. `s_ready`=1 in M+1 if `enable`=1.
- `err_short` and `err_long` are registered and appear in the cycle after the offending handshake.
- `net_done` outside RUN is ignored.

## Structure
- Shared package (`cnp.vh`): DATA_WIDTH, LAYER1_IN_FEATURE_ADDR_WIDTH, the frame size constant and the loader state encoding.
- Single module, no sub-modules. The FSM and word counter are one always block; outputs are registered.

## Test plan
- **Nominal frame:** 1024 words (pixel k = k), `s_valid` held high, `s_last` on word 1023.
  - Writes occur at addresses 0..1023 with data = address.
  - `net_reset` pulses one cycle later, then `net_enable` rises.
  - `net_done` after 50 cycles → `frame_done` 1 cycle later.
- **Backpressure-free gaps:** random `s_valid` gaps (30% idle). Same RAM contents as the nominal frame; no write on idle cycles.
- **Short frame:** `s_last` on word 9.
  - `err_short` pulses, no `net_reset`.
  - The next 1024-word frame is written starting at address 0 and completes normally.
- **Long frame:** 1030 words with `s_last` on the last.
  - `err_long` pulses after word 1023.
  - Words 1024..1029 cause no writes; `net_reset` follows the word-1029 handshake.
- **Enable drop:** `enable`=0 mid-RUN. `net_enable` stays high until `net_done`; then IDLE with `s_ready`=0. Re-raising `enable` resumes in LOAD.
- **Mid-frame reset:** `reset` asserted after word 500. All outputs are 0 the next cycle; a following full frame writes from address 0.
